volume_ctrl: RTL

//   Turns the raw volume-up/volume-down push buttons into a registered volume level and mute flag.

---
 rtl/vol_ctrl_pkg.sv | 32 +++
 rtl/btn_conditioner.sv | 49 ++++
 rtl/volume_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vol_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vol_ctrl_pkg
//   Shared definitions for the volume controller:
//   - vc_state_e  : button FSM states (idle, hold/repeat per direction, chord)
//   - step_dir_e  : direction of a volume step requested by the FSM
//   - cnt_width() : width of the hold/repeat tick counter
// -----------------------------------------------------------------------------
package vol_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UP_HLD = 3'd1,
    ST_UP_RPT = 3'd2,
    ST_DN_HLD = 3'd3,
    ST_DN_RPT = 3'd4,
    ST_CHORD  = 3'd5
  } vc_state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2
  } step_dir_e;

  // Counter only has to reach max(a,b)-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 32'd1) ? $clog2(m) : 32'd1;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Tick-gated debounce for one push button. The raw level is shifted into a
//   DEB_LEN-deep register on every clk edge where tick=1; the debounced output
//   is high only while every stored sample is high, so any low sample inside
//   the window (bounce) keeps it low. Output changes only on tick edges.
// Ports
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset (clears the sample history)
//   tick    in  1-clk sampling strobe
//   btn_raw in  raw button level, active high
//   deb     out debounced level (decoded from the history register)
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int unsigned DEB_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic deb
);

  logic [DEB_LEN-1:0] shift_q;
  logic [DEB_LEN-1:0] shift_d;

  // Next sample history: shift in the raw level on tick, otherwise hold.
  always_comb begin
    shift_d = shift_q;
    if (tick) begin
      shift_d    = shift_q << 1'b1;
      shift_d[0] = btn_raw;
    end else begin
      shift_d = shift_q;
    end
  end

  // Sample history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign deb = &shift_q;

endmodule

// File: rtl/volume_ctrl.sv
// -----------------------------------------------------------------------------
// volume_ctrl
//   Converts raw volume-up / volume-down buttons into a registered volume level
//   and mute flag. A single press steps once; holding auto-repeats after
//   HOLD_TICKS ticks and then every REPEAT_TICKS ticks. Pressing both buttons
//   toggles mute. Steps saturate at 0 / VOL_MAX and always clear mute.
// Ports
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   tick         in  1-clk sampling strobe; all debounce/hold timing counts it
//   vol_up_btn   in  raw up button
//   vol_down_btn in  raw down button
//   vol_level    out current volume (registered)
//   mute         out mute flag (registered)
//   vol_changed  out 1-clk pulse when vol_level or mute changed
//   at_max       out vol_level == VOL_MAX
//   at_min       out vol_level == 0
// -----------------------------------------------------------------------------
module volume_ctrl
  import vol_ctrl_pkg::*;
#(
  parameter int unsigned VOL_W        = 3,
  parameter int unsigned VOL_MAX      = 7,
  parameter int unsigned VOL_INIT     = 4,
  parameter int unsigned DEB_LEN      = 4,
  parameter int unsigned HOLD_TICKS   = 32,
  parameter int unsigned REPEAT_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             vol_up_btn,
  input  logic             vol_down_btn,
  output logic [VOL_W-1:0] vol_level,
  output logic             mute,
  output logic             vol_changed,
  output logic             at_max,
  output logic             at_min
);

  localparam int unsigned      CNT_W      = cnt_width(HOLD_TICKS, REPEAT_TICKS);
  localparam logic [VOL_W-1:0] VOL_MAX_V  = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] VOL_INIT_V = VOL_W'(VOL_INIT);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_TICKS - 1);

  logic             up_deb;
  logic             dn_deb;

  vc_state_e        state_q;
  vc_state_e        state_d;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic [VOL_W-1:0] vol_q;
  logic [VOL_W-1:0] vol_d;
  logic             mute_q;
  logic             mute_d;
  logic             vol_changed_q;
  logic             vol_changed_d;

  step_dir_e        step_dir;
  logic             mute_toggle;

  btn_conditioner #(.DEB_LEN(DEB_LEN)) u_up_cond (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .btn_raw (vol_up_btn),
    .deb     (up_deb)
  );

  btn_conditioner #(.DEB_LEN(DEB_LEN)) u_dn_cond (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .btn_raw (vol_down_btn),
    .deb     (dn_deb)
  );

  // Button FSM: next state, hold counter and step/mute requests.
  // Release of the held button is checked before the other button so a
  // release-and-press in one cycle goes through IDLE first.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    step_dir    = STEP_NONE;
    mute_toggle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (up_deb && dn_deb) begin
          state_d     = ST_CHORD;
          mute_toggle = 1'b1;
        end else if (up_deb) begin
          state_d  = ST_UP_HLD;
          step_dir = STEP_UP;
        end else if (dn_deb) begin
          state_d  = ST_DN_HLD;
          step_dir = STEP_DN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UP_HLD, ST_UP_RPT: begin
        if (!up_deb) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else if (dn_deb) begin
          state_d     = ST_CHORD;
          hold_cnt_d  = '0;
          mute_toggle = 1'b1;
        end else if (tick) begin
          if (hold_cnt_q == ((state_q == ST_UP_HLD) ? HOLD_LAST : RPT_LAST)) begin
            state_d    = ST_UP_RPT;
            hold_cnt_d = '0;
            step_dir   = STEP_UP;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DN_HLD, ST_DN_RPT: begin
        if (!dn_deb) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else if (up_deb) begin
          state_d     = ST_CHORD;
          hold_cnt_d  = '0;
          mute_toggle = 1'b1;
        end else if (tick) begin
          if (hold_cnt_q == ((state_q == ST_DN_HLD) ? HOLD_LAST : RPT_LAST)) begin
            state_d    = ST_DN_RPT;
            hold_cnt_d = '0;
            step_dir   = STEP_DN;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_CHORD: begin
        hold_cnt_d = '0;
        if (!up_deb && !dn_deb) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CHORD;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Volume/mute update: saturating step (which always unmutes) or mute toggle.
  always_comb begin
    vol_d  = vol_q;
    mute_d = mute_q;
    case (step_dir)
      STEP_UP: begin
        mute_d = 1'b0;
        if (vol_q != VOL_MAX_V) begin
          vol_d = vol_q + VOL_W'(1);
        end else begin
          vol_d = vol_q;
        end
      end
      STEP_DN: begin
        mute_d = 1'b0;
        if (vol_q != '0) begin
          vol_d = vol_q - VOL_W'(1);
        end else begin
          vol_d = vol_q;
        end
      end
      STEP_NONE: begin
        if (mute_toggle) begin
          mute_d = ~mute_q;
        end else begin
          mute_d = mute_q;
        end
      end
      default: begin
        vol_d  = vol_q;
        mute_d = mute_q;
      end
    endcase
    // Pulse only on a real change, so a saturated step while unmuted is silent.
    vol_changed_d = (vol_d != vol_q) || (mute_d != mute_q);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      vol_q         <= VOL_INIT_V;
      mute_q        <= 1'b0;
      vol_changed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      vol_q         <= vol_d;
      mute_q        <= mute_d;
      vol_changed_q <= vol_changed_d;
    end
  end

  assign vol_level   = vol_q;
  assign mute        = mute_q;
  assign vol_changed = vol_changed_q;
  assign at_max      = (vol_q == VOL_MAX_V);
  assign at_min      = (vol_q == '0);

endmodule
